// File: rtl/fir_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// fir_cfg_ctrl
//   AXI-lite configuration front end for the FIR engine. Holds the ap_ctrl
//   handshake FSM and the data_length register, and arbitrates the tap
//   coefficient SRAM between AXI accesses (outside RUN) and the engine
//   (during RUN).
//
// Ports
//   axis_clk, axis_rst_n        single clock, async active-low reset
//   aw*/w*/b*                   AXI-lite write address/data/response
//   ar*/r*                      AXI-lite read address/data
//   tap_WE/EN/Di/A, tap_Do      tap SRAM (tap_Do registered, 1-cycle latency)
//   eng_tap_req/idx, eng_tap_gnt engine coefficient fetch port
//   eng_start, eng_len, eng_done engine run control
//
// Address map: 0x00 ap_ctrl {idle,done,start}, 0x10 data_length,
//              0x40 + 4*i tap i (i < Tape_Num); everything else reads 0.
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for ap_start; AXI owns the tap SRAM
//   RUN    | engine running; engine owns the tap SRAM, config writes dropped
//   DONE   | engine finished; left on the first accepted ap_ctrl read
// ---------------------------------------------------------------------------
module fir_cfg_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  // AXI-lite write
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   bvalid,
  input  logic                   bready,
  // AXI-lite read
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  // tap SRAM
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  // engine
  input  logic                   eng_tap_req,
  input  logic [3:0]             eng_tap_idx,
  output logic                   eng_tap_gnt,
  output logic                   eng_start,
  output logic [pDATA_WIDTH-1:0] eng_len,
  input  logic                   eng_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [pADDR_WIDTH-1:0] CTRL_ADDR = '0;
  localparam logic [pADDR_WIDTH-1:0] LEN_ADDR  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(64);
  localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(64 + 4 * Tape_Num);
  localparam logic [pADDR_WIDTH-1:0] TAP_CNT   = pADDR_WIDTH'(Tape_Num);

  logic [1:0]             state;
  logic                   out_of_rst;
  logic [pDATA_WIDTH-1:0] data_length;

  logic                   wr_acc;
  logic                   rd_acc;
  logic                   rd_busy;
  logic                   in_run;
  logic                   aw_tap;
  logic                   ar_tap;
  logic                   eng_hit;
  logic [pADDR_WIDTH-1:0] eng_addr;
  logic [pDATA_WIDTH-1:0] ap_ctrl_val;
  logic [pDATA_WIDTH-1:0] rd_val;
  logic                   rd_sram;

  // Read pipeline stage between acceptance and rvalid: gives the SRAM its
  // cycle of latency and makes every address answer with the same timing.
  logic                   p1_vld;
  logic                   p1_sram;
  logic [pDATA_WIDTH-1:0] p1_val;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && (a >= TAP_BASE) && (a < TAP_END);
  endfunction

  assign in_run = (state == S_RUN);

  // out_of_rst keeps the combinational handshakes quiet while reset is held.
  assign wr_acc  = out_of_rst & awvalid & wvalid & ~bvalid;
  assign rd_acc  = out_of_rst & arvalid & ~rd_busy & ~wr_acc;
  assign awready = wr_acc;
  assign wready  = wr_acc;
  assign arready = rd_acc;

  assign aw_tap = is_tap(awaddr);
  assign ar_tap = is_tap(araddr);

  assign eng_tap_gnt = in_run & eng_tap_req;
  assign eng_addr    = pADDR_WIDTH'({eng_tap_idx, 2'b00});
  assign eng_hit     = eng_tap_gnt & (pADDR_WIDTH'(eng_tap_idx) < TAP_CNT);
  assign eng_len     = data_length;

  // ap_start is the eng_start pulse itself, so it reads 1 only in that cycle.
  assign ap_ctrl_val = pDATA_WIDTH'({~in_run, (state == S_DONE), eng_start});

  // Tap SRAM port mux. The engine can only request in RUN and AXI tap
  // accesses are blocked in RUN, so the two sources never collide.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (eng_hit) begin
      tap_EN = 1'b1;
      tap_A  = eng_addr;
    end else if (wr_acc && aw_tap && !in_run) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = awaddr - TAP_BASE;
      tap_Di = wdata;
    end else if (rd_acc && ar_tap && !in_run) begin
      tap_EN = 1'b1;
      tap_A  = araddr - TAP_BASE;
    end
  end

  // Read value chosen at acceptance; register reads are snapshotted so that
  // the DONE->IDLE move on an ap_ctrl read still returns the DONE status.
  always_comb begin
    rd_val  = '0;
    rd_sram = 1'b0;
    if (araddr == CTRL_ADDR) begin
      rd_val = ap_ctrl_val;
    end else if (araddr == LEN_ADDR) begin
      rd_val = data_length;
    end else if (ar_tap) begin
      if (in_run) rd_val = '1;
      else        rd_sram = 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      out_of_rst <= 1'b0;
      state      <= S_IDLE;
      eng_start  <= 1'b0;
    end else begin
      out_of_rst <= 1'b1;
      eng_start  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_acc && (awaddr == CTRL_ADDR) && wdata[0]) begin
            state     <= S_RUN;
            eng_start <= 1'b1;
          end
        end
        S_RUN: begin
          if (eng_done) state <= S_DONE;
        end
        S_DONE: begin
          if (rd_acc && (araddr == CTRL_ADDR)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      data_length <= '0;
      bvalid      <= 1'b0;
    end else begin
      if (wr_acc && (awaddr == LEN_ADDR) && !in_run) data_length <= wdata;
      if (wr_acc)                bvalid <= 1'b1;
      else if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rd_busy <= 1'b0;
      p1_vld  <= 1'b0;
      p1_sram <= 1'b0;
      p1_val  <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      p1_vld <= rd_acc;
      if (rd_acc) begin
        p1_sram <= rd_sram;
        p1_val  <= rd_val;
      end

      if (rd_acc)                rd_busy <= 1'b1;
      else if (rvalid && rready) rd_busy <= 1'b0;

      if (p1_vld) begin
        rvalid <= 1'b1;
        rdata  <= p1_sram ? tap_Do : p1_val;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
module tb_fir_cfg_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int NTAP   = 11;

  logic        axis_clk;
  logic        axis_rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [11:0] awaddr;
  logic [31:0] wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [11:0] araddr;
  logic [31:0] rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic        eng_tap_req, eng_tap_gnt, eng_start, eng_done;
  logic [3:0]  eng_tap_idx;
  logic [31:0] eng_len;

  int vectors;
  int miscompares;
  int start_cnt;

  // reference model state
  int          m_mode;
  logic [31:0] m_len;
  logic [31:0] m_taps [NTAP];

  fir_cfg_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(NTAP)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_tap_req(eng_tap_req), .eng_tap_idx(eng_tap_idx), .eng_tap_gnt(eng_tap_gnt),
    .eng_start(eng_start), .eng_len(eng_len), .eng_done(eng_done)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  // tap SRAM: registered read, byte write enables
  logic [31:0] sram [1024];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) sram[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= sram[tap_A[11:2]];
    end
  end

  always @(negedge axis_clk) if (eng_start) start_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int tap_idx(input logic [11:0] a);
    int i;
    if (a[1:0] != 2'b00 || a < 12'h040) return -1;
    i = (int'(a) - 64) / 4;
    if (i >= NTAP) return -1;
    return i;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    int i;
    i = tap_idx(a);
    if (a == 12'h000) return (m_mode == M_RUN) ? 32'h0 : (m_mode == M_DONE) ? 32'h6 : 32'h4;
    if (a == 12'h010) return m_len;
    if (i >= 0)       return (m_mode == M_RUN) ? 32'hFFFF_FFFF : m_taps[i];
    return 32'h0;
  endfunction

  function automatic logic [11:0] pick_addr();
    logic [11:0] a;
    case ($urandom_range(0, 5))
      0:       a = 12'h000;
      1:       a = 12'h010;
      2, 3:    a = 12'h040 + 12'(4 * $urandom_range(0, 10));
      4:       a = 12'h040 + 12'(4 * $urandom_range(11, 15));
      default: begin
        case ($urandom_range(0, 3))
          0:       a = 12'h004;
          1:       a = 12'h020;
          2:       a = 12'h042;
          default: a = 12'h0FC;
        endcase
      end
    endcase
    return a;
  endfunction

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    int   sc;
    int   n;
    int   i;
    logic exp_start;
    sc = start_cnt;
    exp_start = (a == 12'h000) && d[0] && (m_mode == M_IDLE);
    @(negedge axis_clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 50) begin @(negedge axis_clk); #1; n++; end
    check_val("aw_accept", 32'(awready & wready), 32'h1);
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("bvalid", 32'(bvalid), 32'h1);
    @(posedge axis_clk); #1;
    check_val("b_clear", 32'(bvalid), 32'h0);
    i = tap_idx(a);
    if (exp_start) m_mode = M_RUN;
    else if (a == 12'h010 && m_mode != M_RUN) m_len = d;
    else if (i >= 0 && m_mode != M_RUN) m_taps[i] = d;
    @(negedge axis_clk);
    check_val("eng_start_cnt", 32'(start_cnt - sc), 32'(exp_start));
    check_val("eng_len", eng_len, m_len);
  endtask

  task automatic bfm_read(input logic [11:0] a, input int dly,
                          output logic [31:0] d, output int lat);
    int n;
    @(negedge axis_clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge axis_clk); #1; n++; end
    check_val("ar_accept", 32'(arready), 32'h1);
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin @(posedge axis_clk); #1; lat++; end
    d = rdata;
    for (int k = 0; k < dly; k++) begin
      @(posedge axis_clk); #1;
      check_val("r_hold", 32'(rvalid), 32'h1);
      check_val("r_stable", rdata, d);
    end
    rready = 1'b1;
    @(posedge axis_clk); #1;
    rready = 1'b0;
    check_val("r_clear", 32'(rvalid), 32'h0);
  endtask

  task automatic do_read(input logic [11:0] a, input int dly);
    logic [31:0] exp;
    logic [31:0] d;
    int          lat;
    exp = exp_rd(a);
    bfm_read(a, dly, d, lat);
    check_val("r_latency", 32'(lat), 32'h2);
    check_val("rdata", d, exp);
    if (a == 12'h000 && m_mode == M_DONE) m_mode = M_IDLE;
  endtask

  task automatic eng_pulse();
    @(negedge axis_clk); eng_done = 1'b1;
    @(negedge axis_clk); eng_done = 1'b0;
    if (m_mode == M_RUN) m_mode = M_DONE;
  endtask

  task automatic eng_probe(input logic [3:0] idx);
    logic inrun;
    logic hit;
    inrun = (m_mode == M_RUN);
    hit   = inrun && (int'(idx) < NTAP);
    @(negedge axis_clk);
    eng_tap_req = 1'b1; eng_tap_idx = idx;
    #1;
    check_val("eng_gnt", 32'(eng_tap_gnt), 32'(inrun));
    check_val("eng_tap_en", 32'(tap_EN), 32'(hit));
    check_val("eng_tap_a", 32'(tap_A), hit ? 32'(4 * int'(idx)) : 32'h0);
    check_val("eng_tap_we", 32'(tap_WE), 32'h0);
    @(posedge axis_clk); #1;
    eng_tap_req = 1'b0;
    if (hit) check_val("eng_tap_do", tap_Do, m_taps[idx]);
  endtask

  initial begin
    int          op;
    int          sc;
    int          lat;
    vectors = 0; miscompares = 0; start_cnt = 0;
    for (int k = 0; k < 1024; k++) sram[k] = 32'h0;
    for (int k = 0; k < NTAP; k++) m_taps[k] = 32'h0;
    m_len = 32'h0; m_mode = M_IDLE;
    axis_rst_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 0;
    awaddr = 0; wdata = 0; araddr = 0;
    eng_tap_req = 0; eng_tap_idx = 0; eng_done = 0;

    // reset state, with requests pushed at the closed door
    repeat (3) @(negedge axis_clk);
    awvalid = 1; wvalid = 1; arvalid = 1; eng_tap_req = 1;
    #1;
    check_val("rst_awready", 32'(awready), 32'h0);
    check_val("rst_wready", 32'(wready), 32'h0);
    check_val("rst_arready", 32'(arready), 32'h0);
    check_val("rst_bvalid", 32'(bvalid), 32'h0);
    check_val("rst_rvalid", 32'(rvalid), 32'h0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_eng_start", 32'(eng_start), 32'h0);
    check_val("rst_eng_gnt", 32'(eng_tap_gnt), 32'h0);
    check_val("rst_tap_en", 32'(tap_EN), 32'h0);
    check_val("rst_tap_we", 32'(tap_WE), 32'h0);
    check_val("rst_eng_len", eng_len, 32'h0);
    awvalid = 0; wvalid = 0; arvalid = 0; eng_tap_req = 0;
    @(negedge axis_clk); axis_rst_n = 1'b1;
    repeat (3) @(negedge axis_clk);
    do_read(12'h000, 0);

    // randomized traffic against the model
    for (int t = 0; t < 80; t++) begin
      op = int'($urandom_range(0, 9));
      if (op < 4)      do_write(pick_addr(), $urandom());
      else if (op < 7) do_read(pick_addr(), int'($urandom_range(0, 2)));
      else if (op < 8) eng_pulse();
      else             eng_probe(4'($urandom_range(0, 15)));
    end
    if (m_mode == M_RUN)  eng_pulse();
    if (m_mode == M_DONE) do_read(12'h000, 0);

    // taps 0..10 = 1..11, read tap 5
    for (int i = 0; i < NTAP; i++) do_write(12'h040 + 12'(4 * i), 32'(i + 1));
    do_read(12'h054, 0);
    do_read(12'h010, 1);

    // data_length then ap_start together with an ap_ctrl read
    do_write(12'h010, 32'd600);
    sc = start_cnt;
    @(negedge axis_clk);
    awaddr = 12'h000; wdata = 32'h1; awvalid = 1; wvalid = 1;
    araddr = 12'h000; arvalid = 1; rready = 1;
    #1;
    check_val("sim_awready", 32'(awready), 32'h1);
    check_val("sim_arready_first", 32'(arready), 32'h0);
    @(posedge axis_clk); #1;
    awvalid = 0; wvalid = 0;
    check_val("sim_bvalid", 32'(bvalid), 32'h1);
    check_val("sim_arready_second", 32'(arready), 32'h1);
    @(posedge axis_clk); #1;
    arvalid = 0;
    lat = 1;
    while (!rvalid && lat < 50) begin @(posedge axis_clk); #1; lat++; end
    check_val("sim_r_latency", 32'(lat), 32'h2);
    check_val("ap_start_cycle", rdata, 32'h1);
    @(posedge axis_clk); #1;
    rready = 0;
    m_mode = M_RUN;
    repeat (3) @(negedge axis_clk);
    check_val("start_pulse_once", 32'(start_cnt - sc), 32'h1);
    check_val("eng_len_600", eng_len, 32'd600);
    do_read(12'h000, 0);

    // RUN: config drops, tap reads blocked, engine owns SRAM
    do_write(12'h04C, 32'h0000_DEAD);
    do_read(12'h04C, 0);
    do_write(12'h010, 32'd5);
    do_read(12'h010, 0);
    do_write(12'h000, 32'h1);
    eng_probe(4'd7);
    eng_probe(4'd12);
    eng_probe(4'd10);

    // DONE handling; ap_start ignored in DONE
    eng_pulse();
    eng_probe(4'd3);
    do_write(12'h000, 32'h1);
    do_read(12'h000, 0);
    do_read(12'h000, 0);
    do_read(12'h04C, 1);

    // reset with a read response pending
    @(negedge axis_clk);
    araddr = 12'h04C; arvalid = 1; rready = 0;
    #1;
    lat = 0;
    while (!arready && lat < 50) begin @(negedge axis_clk); #1; lat++; end
    @(posedge axis_clk); #1;
    arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 50) begin @(posedge axis_clk); #1; lat++; end
    check_val("pend_rvalid", 32'(rvalid), 32'h1);
    #2;
    axis_rst_n = 1'b0;
    #1;
    check_val("rst_mid_rvalid", 32'(rvalid), 32'h0);
    check_val("rst_mid_rdata", rdata, 32'h0);
    m_mode = M_IDLE; m_len = 32'h0;
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1'b1;
    repeat (2) @(negedge axis_clk);
    do_read(12'h000, 0);
    do_read(12'h010, 0);
    do_read(12'h04C, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
